// File: rtl/var_gen_pipe.sv
// rtl/var_gen_pipe.sv - multi-lane two-stage variable generator for div/exp/log (optional rounding: VAR_GEN_PIPE_ROUND_EN)
module var_gen_pipe #(
   parameter int INT_BW = 5,
   parameter int FRA_BW = 10,
   parameter int MUL_BW = 16,
   parameter int LANES  = 4,
   parameter int SH_BW  = $clog2(MUL_BW) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [1:0]                gemm_uno_i,
   input  logic [LANES*MUL_BW-1:0]   x_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES*MUL_BW-1:0]   var_o,
   output logic [LANES*SH_BW-1:0]    shift_o,
   output logic [LANES-1:0]          zero_o,
   output logic [LANES-1:0]          err_o
);

   localparam int LW = $clog2(MUL_BW);
   localparam logic [MUL_BW-1:0] POINT = MUL_BW'(3) << (FRA_BW - 2);
`ifdef VAR_GEN_PIPE_ROUND_EN
   localparam logic [MUL_BW:0]   ONE_W = (MUL_BW+1)'(1) << FRA_BW;
`endif

   localparam logic [1:0] MODE_GEMM = 2'b00;
   localparam logic [1:0] MODE_EXP  = 2'b10;

   // The word layout (sign, integer, fraction) only works if the widths add up.
   if (MUL_BW != 1 + INT_BW + FRA_BW) begin : g_bad_width
      $error("var_gen_pipe: MUL_BW must equal 1+INT_BW+FRA_BW");
   end

   logic [LANES-1:0][MUL_BW-1:0] x_in;
   assign x_in = x_i;

   // stage 1: leading-one index, mode, raw operand, flags
   logic                          s1_valid_q, s1_valid_d;
   logic [1:0]                    s1_mode_q, s1_mode_d;
   logic [LANES-1:0][MUL_BW-1:0]  s1_x_q, s1_x_d;
   logic [LANES-1:0][LW-1:0]      s1_lod_q, s1_lod_d;
   logic [LANES-1:0]              s1_zero_q, s1_zero_d;
   logic [LANES-1:0]              s1_neg_q, s1_neg_d;

   // stage 2: final per-lane results, driving the outputs directly
   logic                          s2_valid_q, s2_valid_d;
   logic [LANES-1:0][MUL_BW-1:0]  s2_var_q, s2_var_d;
   logic [LANES-1:0][SH_BW-1:0]   s2_shift_q, s2_shift_d;
   logic [LANES-1:0]              s2_zero_q, s2_zero_d;
   logic [LANES-1:0]              s2_err_q, s2_err_d;

   logic s1_en, s2_en;

   // A stage may load when it is empty or its contents leave in the same cycle.
   always_comb begin
      s2_en      = !s2_valid_q || out_ready_i;
      s1_en      = !s1_valid_q || s2_en;
      in_ready_o = s1_en;
   end

   // Stage 1 next state: capture the beat and locate each lane's leading one.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_x_d     = s1_x_q;
      s1_lod_d   = s1_lod_q;
      s1_zero_d  = s1_zero_q;
      s1_neg_d   = s1_neg_q;
      if (s1_en) begin
         s1_valid_d = in_valid_i;
         if (in_valid_i) begin
            s1_mode_d = gemm_uno_i;
            s1_x_d    = x_in;
            for (int k = 0; k < LANES; k++) begin
               s1_lod_d[k] = '0;
               // sign bit excluded: negative operands never normalise
               for (int b = 0; b < MUL_BW - 1; b++) begin
                  if (x_in[k][b]) s1_lod_d[k] = LW'(b);
               end
               s1_zero_d[k] = (x_in[k] == '0);
               s1_neg_d[k]  = x_in[k][MUL_BW-1];
            end
         end
      end
   end

   // Stage 2 next state: normalise each lane and form the mode-specific variable.
   always_comb begin
      logic signed [SH_BW-1:0] sh;
      logic [SH_BW-1:0]        rsh;
      logic [MUL_BW-1:0]       xn;
`ifdef VAR_GEN_PIPE_ROUND_EN
      logic [MUL_BW:0]         xw;
`endif
      s2_valid_d = s2_valid_q;
      s2_var_d   = s2_var_q;
      s2_shift_d = s2_shift_q;
      s2_zero_d  = s2_zero_q;
      s2_err_d   = s2_err_q;
      if (s2_en) s2_valid_d = s1_valid_q;
      for (int k = 0; k < LANES; k++) begin
         sh  = SH_BW'(FRA_BW - 1) - SH_BW'(s1_lod_q[k]);
         rsh = SH_BW'(0) - sh;
         if (!sh[SH_BW-1]) begin
            xn = s1_x_q[k] << sh[LW-1:0];
         end else begin
`ifdef VAR_GEN_PIPE_ROUND_EN
            // half-up rounding can carry into 1.0; saturate just below it
            xw = ({1'b0, s1_x_q[k]} + ((MUL_BW+1)'(1) << (rsh - SH_BW'(1)))) >> rsh;
            if (xw >= ONE_W) xn = MUL_BW'(ONE_W - (MUL_BW+1)'(1));
            else             xn = xw[MUL_BW-1:0];
`else
            xn = s1_x_q[k] >> rsh;
`endif
         end
         if (s2_en && s1_valid_q) begin
            s2_var_d[k]   = '0;
            s2_shift_d[k] = '0;
            s2_zero_d[k]  = 1'b0;
            s2_err_d[k]   = 1'b0;
            if (s1_mode_q == MODE_EXP) begin
               s2_var_d[k]  = {{(INT_BW+1){s1_x_q[k][MUL_BW-1]}}, s1_x_q[k][FRA_BW-1:0]};
               s2_zero_d[k] = s1_zero_q[k];
            end else if (s1_mode_q != MODE_GEMM) begin
               // div and log share the normalised polynomial variable
               if (s1_zero_q[k]) begin
                  s2_var_d[k]  = POINT;
                  s2_zero_d[k] = 1'b1;
               end else if (s1_neg_q[k]) begin
                  s2_err_d[k] = 1'b1;
               end else begin
                  s2_var_d[k]   = POINT - xn;
                  s2_shift_d[k] = sh;
               end
            end
         end
      end
   end

   // Stage 1 registers; reset drops any captured beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= '0;
         s1_x_q     <= '0;
         s1_lod_q   <= '0;
         s1_zero_q  <= '0;
         s1_neg_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_mode_q  <= s1_mode_d;
         s1_x_q     <= s1_x_d;
         s1_lod_q   <= s1_lod_d;
         s1_zero_q  <= s1_zero_d;
         s1_neg_q   <= s1_neg_d;
      end
   end

   // Stage 2 registers; these are the visible outputs, cleared on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_var_q   <= '0;
         s2_shift_q <= '0;
         s2_zero_q  <= '0;
         s2_err_q   <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_var_q   <= s2_var_d;
         s2_shift_q <= s2_shift_d;
         s2_zero_q  <= s2_zero_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign out_valid_o = s2_valid_q;
   assign var_o       = s2_var_q;
   assign shift_o     = s2_shift_q;
   assign zero_o      = s2_zero_q;
   assign err_o       = s2_err_q;

endmodule

// File: tb/tb_var_gen_pipe.sv
// tb/tb_var_gen_pipe.sv - directed self-checking bench for var_gen_pipe
module tb_var_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic [63:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] var_w;
   logic [19:0] shift_w;
   logic [3:0]  zero_w;
   logic [3:0]  err_w;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   var_gen_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .gemm_uno_i  (mode),
      .x_i         (x),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .var_o       (var_w),
      .shift_o     (shift_w),
      .zero_o      (zero_w),
      .err_o       (err_w)
   );

   // drive one beat into an idle pipe and wait (bounded) for its result
   task automatic send_beat(input logic [1:0] m, input logic [63:0] xv, output int lat);
      @(negedge clk);
      in_valid = 1'b1; mode = m; x = xv; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; x = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if ({var_w, shift_w, zero_w, err_w} !== 92'd0) begin n_fail++; $display("FAIL rst_outputs got=%h exp=0", {var_w, shift_w, zero_w, err_w}); end
   endtask

   task automatic test_div();
      int lat;
      send_beat(2'b01, {16'h0001, 16'h7FFF, 16'h0040, 16'h0400}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL div_latency got=%0d exp=2", lat); end
      n_cmp++; if (var_w !== {16'h0100, 16'hFF01, 16'h0100, 16'h0100}) begin n_fail++; $display("FAIL div_var got=%h exp=%h", var_w, {16'h0100, 16'hFF01, 16'h0100, 16'h0100}); end
      n_cmp++; if (shift_w !== {5'h09, 5'h1B, 5'h03, 5'h1F}) begin n_fail++; $display("FAIL div_shift got=%h exp=%h", shift_w, {5'h09, 5'h1B, 5'h03, 5'h1F}); end
      n_cmp++; if ({zero_w, err_w} !== 8'h00) begin n_fail++; $display("FAIL div_flags got=%h exp=00", {zero_w, err_w}); end
   endtask

   task automatic test_log_flags();
      int lat;
      send_beat(2'b11, {16'h0300, 16'h8400, 16'h0000, 16'h0040}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL log_latency got=%0d exp=2", lat); end
      n_cmp++; if (var_w !== {16'h0000, 16'h0000, 16'h0300, 16'h0100}) begin n_fail++; $display("FAIL log_var got=%h exp=%h", var_w, {16'h0000, 16'h0000, 16'h0300, 16'h0100}); end
      n_cmp++; if (shift_w !== {5'h00, 5'h00, 5'h00, 5'h03}) begin n_fail++; $display("FAIL log_shift got=%h exp=%h", shift_w, {5'h00, 5'h00, 5'h00, 5'h03}); end
      n_cmp++; if (zero_w !== 4'b0010) begin n_fail++; $display("FAIL log_zero got=%b exp=0010", zero_w); end
      n_cmp++; if (err_w !== 4'b0100) begin n_fail++; $display("FAIL log_err got=%b exp=0100", err_w); end
   endtask

   task automatic test_exp_gemm();
      int lat;
      send_beat(2'b10, {16'h8000, 16'h7FFF, 16'h0C80, 16'hFC80}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL exp_latency got=%0d exp=2", lat); end
      n_cmp++; if (var_w !== {16'hFC00, 16'h03FF, 16'h0080, 16'hFC80}) begin n_fail++; $display("FAIL exp_var got=%h exp=%h", var_w, {16'hFC00, 16'h03FF, 16'h0080, 16'hFC80}); end
      n_cmp++; if ({shift_w, zero_w, err_w} !== 28'd0) begin n_fail++; $display("FAIL exp_shift_flags got=%h exp=0", {shift_w, zero_w, err_w}); end
      send_beat(2'b00, {16'h8400, 16'h0000, 16'h1234, 16'h0400}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL gemm_latency got=%0d exp=2", lat); end
      n_cmp++; if ({var_w, shift_w, zero_w, err_w} !== 92'd0) begin n_fail++; $display("FAIL gemm_outputs got=%h exp=0", {var_w, shift_w, zero_w, err_w}); end
   endtask

   task automatic test_round();
      int lat;
      logic [63:0] exp_var;
`ifdef VAR_GEN_PIPE_ROUND_EN
      exp_var = {16'h0000, 16'hFFFF, 16'hFF01, 16'h00FF};
`else
      exp_var = {16'h0000, 16'h0000, 16'hFF01, 16'h0100};
`endif
      send_beat(2'b01, {16'h0003, 16'h0C03, 16'h07FF, 16'h0401}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL round_latency got=%0d exp=2", lat); end
      n_cmp++; if (var_w !== exp_var) begin n_fail++; $display("FAIL round_var got=%h exp=%h", var_w, exp_var); end
      n_cmp++; if (shift_w !== {5'h08, 5'h1E, 5'h1F, 5'h1F}) begin n_fail++; $display("FAIL round_shift got=%h exp=%h", shift_w, {5'h08, 5'h1E, 5'h1F, 5'h1F}); end
   endtask

   task automatic test_back_to_back();
      int tx = 0;
      int rx = 0;
      logic seen_stall = 1'b0;
      logic prev_hold  = 1'b0;
      logic [63:0] prev_var = '0;
      logic [63:0] exp_var;
      for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 5);
         in_valid  = (tx < 6);
         mode      = 2'b10;
         x         = {32'h0, 16'(16'h0C80 + tx), 16'(16'h0001 + tx)};
         #1;
         if (prev_hold) begin
            n_cmp++;
            if (out_valid !== 1'b1 || var_w !== prev_var) begin
               n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, var_w, prev_var);
            end
         end
         if (!in_ready) seen_stall = 1'b1;
         if (out_valid && out_ready) begin
            exp_var = {32'h0, 16'(16'h0080 + rx), 16'(16'h0001 + rx)};
            n_cmp++; if (var_w !== exp_var) begin n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", rx, var_w, exp_var); end
            rx++;
         end
         prev_hold = out_valid && !out_ready;
         prev_var  = var_w;
         if (in_valid && in_ready) tx++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++; if (rx !== 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", rx); end
      n_cmp++; if (seen_stall !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_low got=%b exp=1", seen_stall); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; mode = 2'b11; out_ready = 1'b1;
      x = {16'h0000, 16'h8400, 16'h0000, 16'h0040};
      @(negedge clk);
      x = {16'h0040, 16'h0000, 16'h8400, 16'h0000};
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if ({var_w, shift_w, zero_w, err_w} !== 92'd0) begin n_fail++; $display("FAIL mrst_outputs got=%h exp=0", {var_w, shift_w, zero_w, err_w}); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_dropped got=%b exp=0", out_valid); end
      send_beat(2'b01, {16'h0400, 16'h0400, 16'h0400, 16'h0400}, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL mrst_new_latency got=%0d exp=2", lat); end
      n_cmp++; if (var_w !== {4{16'h0100}}) begin n_fail++; $display("FAIL mrst_new_var got=%h exp=%h", var_w, {4{16'h0100}}); end
   endtask

   initial begin
      test_reset();
      test_div();
      test_log_flags();
      test_exp_gemm();
      test_round();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
